serial_read_engine_arbiter: RTL and testbench

- Round-robin, burst-locked N:1 arbiter that shares one cache request port among NUM_REQ serial read engines in a graph PE.
- Sits between the engines' request-out FIFOs and the PE cache request path.
- Holds one grant for up to BURST_LEN back-to-back requests, so serial streams stay contiguous.
- Registers the winning request in a one-entry output stage.

---
 rtl/serial_read_engine_arbiter.sv | 149 ++++++++++++++
 tb/tb_serial_read_engine_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_read_engine_arbiter.sv
// Round-robin, burst-locked N:1 arbiter sharing one cache request port among serial read engines.
// The winning request is captured in a one-entry registered output stage.
module serial_read_engine_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 2,
    parameter int BURST_LEN = 4
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  logic                      arb_enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
    output logic                      arb_idle
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;

    logic              load_ok_s;
    logic              in_burst_s;
    logic              sel_valid_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              xfer_s;

    // First valid requester after the previous winner, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign load_ok_s   = !out_valid_q || out_ready;
    assign in_burst_s  = (state_q == ARB_BURST);
    assign sel_valid_s = req_valid[grant_q];
    assign sel_data_s  = req_data[grant_q*DATA_W +: DATA_W];
    assign xfer_s      = in_burst_s && sel_valid_s && load_ok_s;

    assign req_ready = (in_burst_s && load_ok_s) ? (NUM_REQ'(1) << grant_q) : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign arb_idle  = (state_q == ARB_IDLE) && !out_valid_q;

    // Arbitration FSM next state and output-stage next state.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;

        case (state_q)
            ARB_IDLE: begin
                if (arb_enable && (|req_valid)) begin
                    grant_d     = rr_pick(req_valid, last_grant_q);
                    burst_cnt_d = '0;
                    state_d     = ARB_BURST;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BURST: begin
                // A dropped valid ends the burst without a transfer; a stall freezes the count.
                if (!sel_valid_s) begin
                    last_grant_d = grant_q;
                    state_d      = ARB_IDLE;
                end else if (xfer_s) begin
                    if (burst_cnt_q == CNT_LAST) begin
                        last_grant_d = grant_q;
                        state_d      = ARB_IDLE;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ARB_BURST;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_id_d    = grant_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers; reset discards any held request.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
        end
    end

endmodule

// File: tb/tb_serial_read_engine_arbiter.sv
// Directed bench for serial_read_engine_arbiter: engines carry sequence-numbered payloads,
// a queue holds the hand-ordered expected beats and a monitor checks each accepted output.
module tb_serial_read_engine_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int IW = 2;
    localparam int BL = 4;

    typedef logic [IW+DW-1:0] beat_t;

    logic              ap_clk = 1'b0;
    logic              areset;
    logic              arb_enable;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_id;
    logic              out_ready;
    logic              arb_idle;

    beat_t exp_q[$];
    int    seq[NR];
    int    budget[NR];
    int    n_chk = 0;
    int    n_fail = 0;
    int    hs_total = 0;

    serial_read_engine_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .ID_W(IW), .BURST_LEN(BL)
    ) dut (
        .ap_clk(ap_clk), .areset(areset), .arb_enable(arb_enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .arb_idle(arb_idle)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic beat_t mk(input int id, input int s);
        return {IW'(id), 32'(id), 32'(s)};
    endfunction

    task automatic push(input int id, input int s0, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(mk(id, s0 + k));
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = (budget[i] > 0);
            req_data[i*DW +: DW]  = {32'(i), 32'(seq[i])};
        end
    endtask

    // One clock: capture handshakes mid-cycle, then advance engine payloads after the edge.
    task automatic tick();
        logic [NR-1:0] hs;
        @(negedge ap_clk);
        hs = req_valid & req_ready;
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                seq[i]++;
                budget[i]--;
                hs_total++;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        areset     = 1'b1;
        arb_enable = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < NR; i++) begin
            seq[i]    = 0;
            budget[i] = 0;
        end
        drive();
        tick();
        tick();
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_arb_idle", 64'(arb_idle), 64'd1);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        @(posedge ap_clk);
        #1;
        areset = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        logic done;
        done = 1'b0;
        for (int k = 0; k < maxc && !done; k++) begin
            tick();
            #2;
            if (arb_idle && (req_valid == '0) && (exp_q.size() == 0)) done = 1'b1;
        end
        chk({name, "_drain"}, 64'(done), 64'd1);
    endtask

    // Scoreboard monitor: every accepted output beat must match the next expected beat.
    always @(negedge ap_clk) begin
        if (!areset && out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got id %0d data %0h expected none", out_id, out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if ({out_id, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL beat: got id %0d data %0h expected id %0d data %0h",
                             out_id, out_data, e[IW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        req_valid = '0;
        req_data  = '0;

        // Single requester: two bursts of 4 separated by one bubble.
        do_reset();
        push(0, 0, 8);
        budget[0] = 8;
        drive();
        tick();
        #2;
        chk("t1_c1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_c1_req_ready", 64'(req_ready), 64'd1);
        tick();
        #2;
        chk("t1_c2_out_valid", 64'(out_valid), 64'd1);
        for (int c = 3; c <= 6; c++) tick();
        #2;
        chk("t1_c6_bubble", 64'(out_valid), 64'd0);
        wait_idle("t1", 40);

        // All four requesters: order 0,1,2,3,0; 16 transfers in the first 20 cycles.
        do_reset();
        push(0, 0, 4); push(1, 0, 4); push(2, 0, 4); push(3, 0, 4); push(0, 4, 4);
        budget[0] = 8; budget[1] = 4; budget[2] = 4; budget[3] = 4;
        hs_total = 0;
        drive();
        for (int c = 1; c <= 20; c++) tick();
        chk("t2_xfers_in_20", 64'(hs_total), 64'd16);
        wait_idle("t2", 40);

        // Back-pressure for 5 cycles after two beats of engine 1.
        do_reset();
        push(1, 0, 6);
        budget[1] = 6;
        drive();
        for (int c = 1; c <= 3; c++) tick();
        out_ready = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            if (c > 3) tick();
            #2;
            chk("t3_hold_data", out_data, {32'd1, 32'd1});
            chk("t3_hold_id", 64'(out_id), 64'd1);
            chk("t3_stall_ready", 64'(req_ready), 64'd0);
        end
        tick();
        out_ready = 1'b1;
        for (int c = 9; c <= 11; c++) tick();
        #2;
        chk("t3_c11_bubble", 64'(out_valid), 64'd0);
        wait_idle("t3", 40);

        // Early drop: engine 2 stops after 2 beats, engine 3 takes over.
        do_reset();
        push(2, 0, 2); push(3, 0, 4);
        budget[2] = 2; budget[3] = 4;
        drive();
        for (int c = 1; c <= 5; c++) tick();
        #2;
        chk("t4_c5_out_valid", 64'(out_valid), 64'd0);
        chk("t4_c5_grant3", 64'(req_ready), 64'd8);
        wait_idle("t4", 40);

        // arb_enable dropped during engine 1's second beat.
        do_reset();
        push(1, 0, 4); push(2, 0, 4); push(1, 4, 4);
        budget[1] = 8; budget[2] = 4;
        drive();
        tick();
        tick();
        arb_enable = 1'b0;
        for (int c = 3; c <= 7; c++) tick();
        #2;
        chk("t5_disabled_idle", 64'(arb_idle), 64'd1);
        chk("t5_disabled_ready", 64'(req_ready), 64'd0);
        arb_enable = 1'b1;
        tick();
        #2;
        chk("t5_regrant_2", 64'(req_ready), 64'd4);
        wait_idle("t5", 60);

        // Asynchronous reset mid-burst; the held beat is discarded and engine 0 wins afterwards.
        do_reset();
        push(0, 0, 1);
        budget[0] = 8;
        drive();
        for (int c = 1; c <= 3; c++) tick();
        #1;
        areset = 1'b1;
        #1;
        chk("t6_async_out_valid", 64'(out_valid), 64'd0);
        chk("t6_async_req_ready", 64'(req_ready), 64'd0);
        chk("t6_async_idle", 64'(arb_idle), 64'd1);
        tick();
        chk("t6_consumed", 64'(seq[0]), 64'd2);
        push(0, 2, 4); push(3, 0, 4); push(0, 6, 2);
        budget[3] = 4;
        drive();
        areset = 1'b0;
        wait_idle("t6", 60);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
